// File: rtl/tt_um_ringosc_freq_meter_if.sv
// ---------------------------------------------------------------------------
// tt_um_ringosc_freq_meter_if
// Bundles the standard Tiny Tapeout pin set used by the ring-oscillator
// frequency meter. Signal names are kept identical to the Tiny Tapeout pins.
//   ui_in   [7:0] : dedicated inputs  (sig, start, cont, byte_sel)
//   uo_out  [7:0] : dedicated outputs (selected result byte)
//   uio_in  [7:0] : bidirectional inputs (unused)
//   uio_out [7:0] : bidirectional outputs (busy, done, ovf, sig_sync)
//   uio_oe  [7:0] : bidirectional output enables
//   ena           : design enable (ignored)
// Modports: master = environment driving the pins, slave = the meter.
// ---------------------------------------------------------------------------
interface tt_um_ringosc_freq_meter_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in, uio_in, ena,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ui_in, uio_in, ena,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_ringosc_freq_meter.sv
// ---------------------------------------------------------------------------
// tt_um_ringosc_freq_meter
// Counts rising edges of an asynchronous input (ui_in[0]) over a gate window
// of 2^GATE_LOG2 clk cycles and latches the count into a result register that
// is read one byte at a time on uo_out.
//
// Parameters:
//   GATE_LOG2 : gate window is 2^GATE_LOG2 clk cycles (default 10)
//   CNT_W     : edge counter / result width, 8..16 (default 16)
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tt_if : Tiny Tapeout pins (slave side)
//           ui_in[0] sig, [1] start (rising edge), [2] cont, [3] byte_sel
//           uo_out   result[7:0] or result[CNT_W-1:8] zero-extended
//           uio_out  [0] busy, [1] done, [2] ovf, [3] sig_sync, [7:4] 0
//           uio_oe   constant 8'h0F
// Optional feature macro: FREQ_METER_CONT_EN
//   defined   : ui_in[2] enables back-to-back continuous windows
//   undefined : ui_in[2] ignored, every window ends in IDLE
// ---------------------------------------------------------------------------
module tt_um_ringosc_freq_meter #(
    parameter int GATE_LOG2 = 10,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tt_um_ringosc_freq_meter_if.slave  tt_if
);

    typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

    localparam logic [GATE_LOG2-1:0] TIMER_MAX = '1;
    localparam logic [GATE_LOG2-1:0] TIMER_ONE = GATE_LOG2'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [GATE_LOG2-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   ovf_run_q, ovf_run_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    // Two-flop synchronisers plus one delayed copy for edge detection.
    logic [1:0]             sig_sync_q, start_sync_q;
    logic                   sig_prev_q, start_prev_q;
    logic                   sig_rise, start_rise;

    logic                   cont;
    logic                   unused_ok;
    logic [CNT_W-1:0]       cnt_step;
    logic                   ovf_step;
    logic                   sat;
    logic [15:0]            result_ext;

`ifdef FREQ_METER_CONT_EN
    assign cont      = tt_if.ui_in[2];
    assign unused_ok = &{1'b0, tt_if.ena, tt_if.uio_in, tt_if.ui_in[7:4]};
`else
    assign cont      = 1'b0;
    assign unused_ok = &{1'b0, tt_if.ena, tt_if.uio_in, tt_if.ui_in[7:4],
                         tt_if.ui_in[2]};
`endif

    assign sig_rise   = sig_sync_q[1]   & ~sig_prev_q;
    assign start_rise = start_sync_q[1] & ~start_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_sync_q   <= 2'b00;
            start_sync_q <= 2'b00;
            sig_prev_q   <= 1'b0;
            start_prev_q <= 1'b0;
            state_q      <= IDLE;
            timer_q      <= '0;
            edge_cnt_q   <= '0;
            ovf_run_q    <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sig_sync_q   <= {sig_sync_q[0], tt_if.ui_in[0]};
            start_sync_q <= {start_sync_q[0], tt_if.ui_in[1]};
            sig_prev_q   <= sig_sync_q[1];
            start_prev_q <= start_sync_q[1];
            state_q      <= state_d;
            timer_q      <= timer_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_run_q    <= ovf_run_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        ovf_run_d  = ovf_run_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        done_d     = done_q;

        // Count this cycle's edge (saturating); an edge arriving at the
        // ceiling is remembered as an overflow instead of wrapping.
        sat      = (edge_cnt_q == CNT_MAX);
        cnt_step = edge_cnt_q;
        if (sig_rise && !sat) begin
            cnt_step = edge_cnt_q + CNT_ONE;
        end
        ovf_step = ovf_run_q | (sig_rise & sat);

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d    = GATE;
                    timer_d    = TIMER_MAX;
                    edge_cnt_d = '0;
                    ovf_run_d  = 1'b0;
                    done_d     = 1'b0;
                end
            end
            GATE: begin
                if (timer_q == '0) begin
                    // Last window cycle: latch the count including this
                    // cycle's edge, then either reload or stop.
                    result_d = cnt_step;
                    ovf_d    = ovf_step;
                    done_d   = 1'b1;
                    if (cont) begin
                        timer_d    = TIMER_MAX;
                        edge_cnt_d = '0;
                        ovf_run_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d    = timer_q - TIMER_ONE;
                    edge_cnt_d = cnt_step;
                    ovf_run_d  = ovf_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-extend so the upper byte reads 0 when CNT_W is 8.
    assign result_ext   = 16'(result_q);
    assign tt_if.uo_out = tt_if.ui_in[3] ? result_ext[15:8] : result_ext[7:0];
    assign tt_if.uio_out = {4'b0000, sig_sync_q[1], ovf_q, done_q,
                            (state_q == GATE)};
    assign tt_if.uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_ringosc_freq_meter.sv
module tb_tt_um_ringosc_freq_meter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_um_ringosc_freq_meter_if if_a ();
    tt_um_ringosc_freq_meter_if if_b ();

    logic sig_r   = 1'b0;
    logic start_a = 1'b0;
    logic cont_a  = 1'b0;
    logic bsel_a  = 1'b0;
    logic start_b = 1'b0;
    logic bsel_b  = 1'b0;

    assign if_a.ui_in  = {4'h0, bsel_a, cont_a, start_a, sig_r};
    assign if_a.uio_in = 8'h00;
    assign if_a.ena    = 1'b1;
    assign if_b.ui_in  = {4'h0, bsel_b, 1'b0, start_b, sig_r};
    assign if_b.uio_in = 8'h00;
    assign if_b.ena    = 1'b1;

    tt_um_ringosc_freq_meter dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .tt_if (if_a)
    );

    tt_um_ringosc_freq_meter #(.GATE_LOG2(10), .CNT_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .tt_if (if_b)
    );

    // Test signal generator: half period in clk cycles, 0 = hold sig_level.
    int   sig_half  = 0;
    logic sig_level = 1'b0;
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (sig_half == 0) begin
                sig_r = sig_level;
                cnt   = 0;
            end else begin
                cnt++;
                if (cnt >= sig_half) begin
                    cnt   = 0;
                    sig_r = ~sig_r;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] uio_of(input bit b);
        return b ? if_b.uio_out : if_a.uio_out;
    endfunction

    task automatic set_start(input bit b, input logic v);
        if (b) start_b = v;
        else   start_a = v;
    endtask

    task automatic set_bsel(input bit b, input logic v);
        if (b) bsel_b = v;
        else   bsel_a = v;
    endtask

    task automatic read_result(input bit b, output logic [15:0] r);
        set_bsel(b, 1'b0);
        #1;
        r[7:0] = b ? if_b.uo_out : if_a.uo_out;
        set_bsel(b, 1'b1);
        #1;
        r[15:8] = b ? if_b.uo_out : if_a.uo_out;
        set_bsel(b, 1'b0);
        #1;
    endtask

    // One measurement: expectations go to the scoreboard when start is
    // driven, and are popped once the window has ended.
    task automatic run_meas(input bit b, input string tag,
                            input logic [15:0] exp_res, input logic exp_ovf,
                            input int restart_at);
        int          n;
        int          len;
        logic [15:0] r;
        exp_t        e;
        sb.push_back('{res: exp_res, ovf: exp_ovf, busy: 1'b0});
        @(negedge clk);
        set_start(b, 1'b1);
        n = 0;
        while (!uio_of(b)[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_rise"}, 32'(uio_of(b)[0]), 32'd1);
        check({tag, "_done_clr"}, 32'(uio_of(b)[1]), 32'd0);
        set_start(b, 1'b0);
        len = 0;
        while (uio_of(b)[0] && len < 3000) begin
            len++;
            if (restart_at != 0 && len == restart_at)     set_start(b, 1'b1);
            if (restart_at != 0 && len == restart_at + 6) set_start(b, 1'b0);
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(len), 32'd1024);
        read_result(b, r);
        e = sb.pop_front();
        check({tag, "_result"}, 32'(r), 32'(e.res));
        check({tag, "_ovf"}, 32'(uio_of(b)[2]), 32'(e.ovf));
        check({tag, "_done"}, 32'(uio_of(b)[1]), 32'd1);
        check({tag, "_busy_end"}, 32'(uio_of(b)[0]), 32'(e.busy));
        $display("txn %s result=%04h ovf=%b busy_cycles=%0d", tag, r,
                 uio_of(b)[2], len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        exp_t        e;
        int          n;
        int          busy_total;

        // Reset state
        repeat (4) @(negedge clk);
        read_result(1'b0, r);
        check("rst_result_a", 32'(r), 32'd0);
        check("rst_uio_out_a", 32'(if_a.uio_out), 32'h00);
        check("rst_uio_oe_a", 32'(if_a.uio_oe), 32'h0F);
        check("rst_uio_out_b", 32'(if_b.uio_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(if_a.uio_out[0]), 32'd0);

        // Periodic input clk/8 -> 128
        sig_half = 4;
        repeat (10) @(negedge clk);
        run_meas(1'b0, "clk_div8", 16'd128, 1'b0, 0);

        // Constant inputs -> 0
        sig_half = 0; sig_level = 1'b0;
        repeat (10) @(negedge clk);
        run_meas(1'b0, "const0", 16'd0, 1'b0, 0);
        sig_level = 1'b1;
        repeat (10) @(negedge clk);
        run_meas(1'b0, "const1", 16'd0, 1'b0, 0);

        // Overflow with 8-bit counter, then recovery
        sig_half = 1;
        repeat (10) @(negedge clk);
        run_meas(1'b1, "ovf_div2", 16'h00FF, 1'b1, 0);
        sig_half = 8;
        repeat (10) @(negedge clk);
        run_meas(1'b1, "b_div16", 16'd64, 1'b0, 0);

        // Second start mid-window is ignored
        sig_half = 4;
        repeat (10) @(negedge clk);
        run_meas(1'b0, "restart_ign", 16'd128, 1'b0, 300);

        // Continuous mode (or single window when the feature is absent)
`ifdef FREQ_METER_CONT_EN
        sb.push_back('{res: 16'd128, ovf: 1'b0, busy: 1'b1});
        sb.push_back('{res: 16'd128, ovf: 1'b0, busy: 1'b1});
        sb.push_back('{res: 16'd256, ovf: 1'b0, busy: 1'b1});
        sb.push_back('{res: 16'd256, ovf: 1'b0, busy: 1'b0});
`else
        repeat (4) sb.push_back('{res: 16'd128, ovf: 1'b0, busy: 1'b0});
`endif
        cont_a  = 1'b1;
        start_a = 1'b1;
        n = 0;
        while (!if_a.uio_out[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cont_busy_rise", 32'(if_a.uio_out[0]), 32'd1);
        start_a = 1'b0;
        busy_total = 0;
        for (int k = 1; k <= 5121; k++) begin
            if (if_a.uio_out[0]) busy_total++;
            if (k == 1025 || k == 2049 || k == 4097 || k == 5121) begin
                read_result(1'b0, r);
                e = sb.pop_front();
                check($sformatf("cont_res_%0d", k), 32'(r), 32'(e.res));
                check($sformatf("cont_busy_%0d", k), 32'(if_a.uio_out[0]),
                      32'(e.busy));
                check($sformatf("cont_done_%0d", k), 32'(if_a.uio_out[1]),
                      32'd1);
                check($sformatf("cont_ovf_%0d", k), 32'(if_a.uio_out[2]),
                      32'(e.ovf));
                $display("txn cont_cycle_%0d result=%04h busy=%b", k, r,
                         if_a.uio_out[0]);
                if (k == 2049) sig_half = 2;
                if (k == 4097) cont_a = 1'b0;
            end
            @(negedge clk);
        end
`ifdef FREQ_METER_CONT_EN
        check("cont_busy_total", 32'(busy_total), 32'd5120);
`else
        check("cont_busy_total", 32'(busy_total), 32'd1024);
`endif

        // Reset in the middle of a window
        sig_half = 4;
        repeat (10) @(negedge clk);
        start_a = 1'b1;
        n = 0;
        while (!if_a.uio_out[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        repeat (500) @(negedge clk);
        check("pre_rst_busy", 32'(if_a.uio_out[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        read_result(1'b0, r);
        check("midrst_result", 32'(r), 32'd0);
        check("midrst_uio_a", 32'(if_a.uio_out), 32'h00);
        check("midrst_uio_b", 32'(if_b.uio_out), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_rst_busy", 32'(if_a.uio_out[0]), 32'd0);
        check("after_rst_done", 32'(if_a.uio_out[1]), 32'd0);
        run_meas(1'b0, "after_rst", 16'd128, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
